// File: rtl/sdram_ch3_arbiter.sv
// sdram_ch3_arbiter: round-robin sharing of SDRAM channel 3 among NCLIENT requesters,
// with refresh pulses slotted into idle gaps and a ready timeout.
module sdram_ch3_arbiter #(
  parameter int NCLIENT     = 3,
  parameter int RFSH_PERIOD = 400,
  parameter int RFSH_HOLD   = 8,
  parameter int TIMEOUT     = 63
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCLIENT-1:0]    cl_req,
  input  logic [NCLIENT-1:0]    cl_rnw,
  input  logic [NCLIENT*26-1:0] cl_addr,
  input  logic [NCLIENT*16-1:0] cl_din,
  input  logic [NCLIENT*2-1:0]  cl_be,
  output logic [NCLIENT-1:0]    cl_ack,
  output logic [15:0]           cl_dout,
  output logic                  cl_err,
  output logic                  ch3_req,
  output logic                  ch3_rnw,
  output logic [25:0]           ch3_addr,
  output logic [15:0]           ch3_din,
  output logic [1:0]            ch3_be,
  input  logic                  ch3_ready,
  input  logic [15:0]           ch3_dout,
  output logic                  doRefresh
);
  localparam int GW = $clog2(NCLIENT);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RFSH_PERIOD + 1);
  localparam int HW = $clog2(RFSH_HOLD + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, ACK, GAP, RFSH} state_t;
  state_t          r_state;
  logic [GW-1:0]   r_ptr, r_gnt, w_gnt;
  logic [TW-1:0]   r_tcnt;
  logic [RW-1:0]   r_rcnt;
  logic [HW-1:0]   r_hcnt;
  logic            w_any, w_rfsh_due;
  assign w_rfsh_due = r_rcnt == RW'(RFSH_PERIOD);
  // Scan from the farthest candidate inward so the nearest requester at/after r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int d = NCLIENT - 1; d >= 0; d--)
      if (cl_req[(int'(r_ptr) + d) % NCLIENT]) begin
        w_any = 1'b1;
        w_gnt = GW'((int'(r_ptr) + d) % NCLIENT);
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_tcnt    <= '0;
      r_rcnt    <= '0;
      r_hcnt    <= '0;
      cl_ack    <= '0;
      cl_dout   <= '0;
      cl_err    <= 1'b0;
      ch3_req   <= 1'b0;
      ch3_rnw   <= 1'b0;
      ch3_addr  <= '0;
      ch3_din   <= '0;
      ch3_be    <= '0;
      doRefresh <= 1'b0;
    end else begin
      r_rcnt    <= (r_state == IDLE && w_rfsh_due) ? '0 : w_rfsh_due ? r_rcnt : r_rcnt + RW'(1);
      doRefresh <= 1'b0;
      cl_ack    <= '0;
      cl_err    <= 1'b0;
      case (r_state)
        IDLE:
          if (w_rfsh_due) begin
            doRefresh <= 1'b1;
            r_hcnt    <= '0;
            r_state   <= RFSH;
          end else if (w_any) begin
            r_gnt    <= w_gnt;
            ch3_req  <= 1'b1;
            ch3_rnw  <= cl_rnw[w_gnt];
            ch3_addr <= cl_addr[w_gnt*26 +: 26];
            ch3_din  <= cl_din[w_gnt*16 +: 16];
            ch3_be   <= cl_be[w_gnt*2 +: 2];
            r_tcnt   <= '0;
            r_state  <= ISSUE;
          end
        ISSUE: begin
          r_tcnt <= r_tcnt + TW'(1);
          // Ready in the final allowed cycle still counts as success.
          if (ch3_ready || r_tcnt == TW'(TIMEOUT - 1)) begin
            ch3_req <= 1'b0;
            cl_ack  <= NCLIENT'(1) << r_gnt;
            cl_err  <= !ch3_ready;
            if (ch3_ready && ch3_rnw) cl_dout <= ch3_dout;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_ptr   <= (r_gnt == GW'(NCLIENT - 1)) ? '0 : r_gnt + GW'(1);
          r_state <= GAP;
        end
        GAP: r_state <= IDLE;
        RFSH: begin
          r_hcnt <= r_hcnt + HW'(1);
          if (r_hcnt == HW'(RFSH_HOLD - 1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_ch3_arbiter.sv
// tb_sdram_ch3_arbiter: scenario tasks plus random traffic checked against a
// round-robin/refresh/timeout reference model and a per-cycle protocol monitor.
module tb_sdram_ch3_arbiter;
  localparam int N = 3, PERIOD = 20, HOLD = 8, TMO = 63;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [N-1:0] cl_req = '0, cl_rnw = '0, cl_ack;
  logic [N*26-1:0] cl_addr = '0;
  logic [N*16-1:0] cl_din = '0;
  logic [N*2-1:0] cl_be = '0;
  logic [15:0] cl_dout, ch3_din, ch3_dout = '0;
  logic cl_err, ch3_req, ch3_rnw, ch3_ready = 1'b0, doRefresh;
  logic [25:0] ch3_addr;
  logic [1:0] ch3_be;
  int errs = 0, checks = 0;
  int exp_ptr = 0;
  logic [15:0] exp_dout = '0;
  int low_run = 0;
  logic prev_req = 1'b0, prev_rf = 1'b0;
  logic [44:0] prev_fields = '0;

  sdram_ch3_arbiter #(.NCLIENT(N), .RFSH_PERIOD(PERIOD), .RFSH_HOLD(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .cl_req(cl_req), .cl_rnw(cl_rnw), .cl_addr(cl_addr),
    .cl_din(cl_din), .cl_be(cl_be), .cl_ack(cl_ack), .cl_dout(cl_dout), .cl_err(cl_err),
    .ch3_req(ch3_req), .ch3_rnw(ch3_rnw), .ch3_addr(ch3_addr), .ch3_din(ch3_din),
    .ch3_be(ch3_be), .ch3_ready(ch3_ready), .ch3_dout(ch3_dout), .doRefresh(doRefresh));

  always #5 clk = ~clk;

  // Protocol invariants that must hold on every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if ($countones(cl_ack) > 1 || (cl_err === 1'b1 && cl_ack === '0)) begin
        errs++; $display("FAIL mon_ack: cl_ack=%b cl_err=%b, want one-hot0 ack and err only with ack", cl_ack, cl_err);
      end
      checks++;
      if (doRefresh === 1'b1 && (ch3_req === 1'b1 || prev_rf === 1'b1)) begin
        errs++; $display("FAIL mon_rfsh: doRefresh=%b ch3_req=%b prev_rf=%b, want single pulse with req low", doRefresh, ch3_req, prev_rf);
      end
      if (ch3_req === 1'b1 && !prev_req) begin
        checks++;
        if (low_run < 2) begin errs++; $display("FAIL mon_req_gap: low cycles=%0d, want >=2", low_run); end
      end
      if (ch3_req === 1'b1 && prev_req) begin
        checks++;
        if ({ch3_rnw, ch3_addr, ch3_din, ch3_be} !== prev_fields) begin
          errs++; $display("FAIL mon_hold: fields=%h, want %h", {ch3_rnw, ch3_addr, ch3_din, ch3_be}, prev_fields);
        end
      end
    end
    low_run = (ch3_req === 1'b1) ? 0 : low_run + 1;
    prev_req = (ch3_req === 1'b1);
    prev_rf = (doRefresh === 1'b1);
    prev_fields = {ch3_rnw, ch3_addr, ch3_din, ch3_be};
  end

  function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
    for (int d = 0; d < N; d++) if (req[(ptr + d) % N]) return (ptr + d) % N;
    return -1;
  endfunction

  task automatic set_fields(input int c);
    cl_rnw[c] = 1'($urandom_range(0, 1));
    cl_addr[c*26 +: 26] = 26'($urandom);
    cl_din[c*16 +: 16] = 16'($urandom);
    cl_be[c*2 +: 2] = 2'($urandom_range(1, 3));
  endtask

  // Slave side of one access: lat = ISSUE cycles before the ready cycle; lat >= TMO means no ready.
  task automatic serve(input int lat, input logic [15:0] rd, input bit keep);
    int g, n;
    logic [N-1:0] oh;
    g = rr_pick(exp_ptr, cl_req);
    n = 0;
    while (ch3_req !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (ch3_req !== 1'b1 || g < 0) begin
      errs++; $display("FAIL grant_wait: ch3_req=%b after %0d cycles, want 1 (model grant %0d)", ch3_req, n, g);
      return;
    end
    checks++;
    if ({ch3_rnw, ch3_addr, ch3_din, ch3_be} !== {cl_rnw[g], cl_addr[g*26 +: 26], cl_din[g*16 +: 16], cl_be[g*2 +: 2]}) begin
      errs++; $display("FAIL fields: got %h, want %h (client %0d)", {ch3_rnw, ch3_addr, ch3_din, ch3_be},
                       {cl_rnw[g], cl_addr[g*26 +: 26], cl_din[g*16 +: 16], cl_be[g*2 +: 2]}, g);
    end
    oh = N'(1 << g);
    if (lat < TMO) begin
      repeat (lat) @(negedge clk);
      ch3_ready = 1'b1; ch3_dout = rd;
      @(negedge clk);
      ch3_ready = 1'b0; ch3_dout = 16'($urandom);
      if (cl_rnw[g]) exp_dout = rd;
      checks++;
      if (cl_ack !== oh || cl_err !== 1'b0 || cl_dout !== exp_dout || ch3_req !== 1'b0) begin
        errs++; $display("FAIL ack: ack=%b err=%b dout=%h req=%b, want ack=%b err=0 dout=%h req=0",
                         cl_ack, cl_err, cl_dout, ch3_req, oh, exp_dout);
      end
    end else begin
      n = 0;
      do begin @(negedge clk); n++; end while (cl_ack === '0 && n < 100);
      checks++;
      if (n != TMO || cl_ack !== oh || cl_err !== 1'b1 || cl_dout !== exp_dout || ch3_req !== 1'b0) begin
        errs++; $display("FAIL timeout: after %0d cycles ack=%b err=%b dout=%h req=%b, want %0d cycles ack=%b err=1 dout=%h req=0",
                         n, cl_ack, cl_err, cl_dout, ch3_req, TMO, oh, exp_dout);
      end
    end
    exp_ptr = (g + 1) % N;
    if (keep) set_fields(g); else cl_req[g] = 1'b0;
    @(negedge clk);
    checks++;
    if (cl_ack !== '0 || cl_err !== 1'b0 || cl_dout !== exp_dout) begin
      errs++; $display("FAIL ack_width: ack=%b err=%b dout=%h, want 0 0 %h", cl_ack, cl_err, cl_dout, exp_dout);
    end
  endtask

  task automatic test_reset;
    for (int c = 0; c < N; c++) set_fields(c);
    cl_req = '1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cl_ack, cl_dout, cl_err, ch3_req, ch3_rnw, ch3_addr, ch3_din, ch3_be, doRefresh} !== '0) begin
      errs++; $display("FAIL reset_async: outputs=%h, want 0", {cl_ack, cl_dout, cl_err, ch3_req, ch3_rnw, ch3_addr, ch3_din, ch3_be, doRefresh});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({cl_ack, cl_dout, cl_err, ch3_req, ch3_rnw, ch3_addr, ch3_din, ch3_be, doRefresh} !== '0) begin
      errs++; $display("FAIL reset_hold: outputs=%h, want 0", {cl_ack, cl_dout, cl_err, ch3_req, ch3_rnw, ch3_addr, ch3_din, ch3_be, doRefresh});
    end
    cl_req = '0;
    reset_n = 1'b1;
    exp_ptr = 0; exp_dout = '0;
  endtask

  // Idle refresh cadence: counter reaches PERIOD, pulse issues on the following edge.
  task automatic test_refresh_idle;
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (doRefresh !== 1'b1 && n < 60);
    checks++;
    if (n != PERIOD + 1) begin errs++; $display("FAIL rfsh_first: pulse after %0d cycles, want %0d", n, PERIOD + 1); end
    n = 1;
    @(negedge clk);
    checks++;
    if (doRefresh !== 1'b0) begin errs++; $display("FAIL rfsh_width: doRefresh=%b, want 0", doRefresh); end
    while (doRefresh !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (n != PERIOD + 1) begin errs++; $display("FAIL rfsh_period: interval %0d, want %0d", n, PERIOD + 1); end
    set_fields(2);
    cl_req = 3'b100;
    n = 0;
    repeat (HOLD) begin @(negedge clk); if (ch3_req !== 1'b0) n++; end
    checks++;
    if (n != 0) begin errs++; $display("FAIL rfsh_hold: ch3_req high in %0d hold cycles, want 0", n); end
    @(negedge clk);
    checks++;
    if (ch3_req !== 1'b1) begin errs++; $display("FAIL rfsh_release: ch3_req=%b, want 1", ch3_req); end
    serve(3, 16'($urandom), 1'b0);
  endtask

  task automatic test_single_write;
    cl_rnw[0] = 1'b0; cl_addr[25:0] = 26'h0001234; cl_din[15:0] = 16'hBEEF; cl_be[1:0] = 2'b11;
    cl_req = 3'b001;
    serve(4, 16'h1357, 1'b0);
  endtask

  task automatic test_single_read;
    int n;
    set_fields(1); cl_rnw[1] = 1'b1;
    cl_req = 3'b010;
    serve(2, 16'h5A5A, 1'b0);
    n = 0;
    repeat (4) begin @(negedge clk); if (cl_dout !== 16'h5A5A) n++; end
    checks++;
    if (n != 0) begin errs++; $display("FAIL read_hold: cl_dout=%h, want 5a5a", cl_dout); end
    set_fields(2); cl_rnw[2] = 1'b0;
    cl_req = 3'b100;
    serve(5, 16'h1111, 1'b0);
  endtask

  task automatic test_fairness;
    for (int c = 0; c < N; c++) set_fields(c);
    cl_req = '1;
    for (int i = 0; i < 2 * N; i++) serve($urandom_range(0, 6), 16'($urandom), 1'b1);
    cl_req = '0;
  endtask

  // A long access saturates the refresh counter; refresh must beat the pending client.
  task automatic test_refresh_priority;
    int n;
    set_fields(0); set_fields(1);
    cl_req = 3'b011;
    serve(25, 16'($urandom), 1'b0);
    @(negedge clk);
    checks++;
    if (doRefresh !== 1'b0 || ch3_req !== 1'b0) begin errs++; $display("FAIL prio_idle: doRefresh=%b ch3_req=%b, want 0 0", doRefresh, ch3_req); end
    @(negedge clk);
    checks++;
    if (doRefresh !== 1'b1 || ch3_req !== 1'b0) begin errs++; $display("FAIL prio_rfsh: doRefresh=%b ch3_req=%b, want 1 0", doRefresh, ch3_req); end
    n = 0;
    repeat (HOLD) begin @(negedge clk); if (ch3_req !== 1'b0 || doRefresh !== 1'b0) n++; end
    checks++;
    if (n != 0) begin errs++; $display("FAIL prio_hold: %0d busy hold cycles, want 0", n); end
    @(negedge clk);
    checks++;
    if (ch3_req !== 1'b1) begin errs++; $display("FAIL prio_grant: ch3_req=%b, want 1", ch3_req); end
    serve(1, 16'($urandom), 1'b0);
  endtask

  task automatic test_timeout;
    set_fields(0); set_fields(2); cl_rnw[0] = 1'b1;
    cl_req = 3'b101;
    serve(TMO, 16'($urandom), 1'b0);
    serve(TMO - 1, 16'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid;
    int n, g;
    for (int c = 0; c < N; c++) set_fields(c);
    cl_req = '1;
    g = rr_pick(exp_ptr, cl_req);
    n = 0;
    while (ch3_req !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (ch3_req !== 1'b1 || ch3_addr !== cl_addr[g*26 +: 26]) begin
      errs++; $display("FAIL mid_grant: req=%b addr=%h, want 1 %h", ch3_req, ch3_addr, cl_addr[g*26 +: 26]);
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ch3_req !== 1'b0 || cl_ack !== '0) begin errs++; $display("FAIL mid_reset: req=%b ack=%b, want 0 0", ch3_req, cl_ack); end
    n = 0;
    repeat (2) begin @(negedge clk); if (ch3_req !== 1'b0 || cl_ack !== '0) n++; end
    checks++;
    if (n != 0) begin errs++; $display("FAIL mid_reset_hold: %0d active cycles, want 0", n); end
    reset_n = 1'b1;
    exp_ptr = 0; exp_dout = '0;
    serve($urandom_range(0, 4), 16'($urandom), 1'b0);
    cl_req = '0;
  endtask

  task automatic test_random;
    int c;
    for (int it = 0; it < 40; it++) begin
      if (cl_req == '0) begin c = $urandom_range(0, N - 1); set_fields(c); cl_req[c] = 1'b1; end
      serve(($urandom_range(0, 14) == 0) ? TMO : $urandom_range(0, 12), 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        ch3_ready = 1'b1; ch3_dout = 16'($urandom);
        @(negedge clk);
        ch3_ready = 1'b0;
        checks++;
        if (cl_ack !== '0 || cl_dout !== exp_dout) begin
          errs++; $display("FAIL stray_ready: ack=%b dout=%h, want 0 %h", cl_ack, cl_dout, exp_dout);
        end
      end
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 2) == 0) begin
          if (!cl_req[k]) set_fields(k);
          cl_req[k] = ~cl_req[k];
        end
    end
  endtask

  initial begin
    test_reset;
    test_refresh_idle;
    test_single_write;
    test_single_read;
    test_fairness;
    test_refresh_priority;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sdram_ch3_arbiter.md
Name: sdram_ch3_arbiter

Overview:
- Round-robin arbiter that shares the SDRAM controller's general-purpose read/write port (channel 3) among several requesters. Typical requesters are the ROM download writer, CPU work RAM and sprite DMA.
- Converts each client's level request/ack handshake into the controller's rising-edge request and one-cycle ready protocol.
- Holds address, data and byte enables stable for the whole access.
- Schedules explicit refresh pulses into idle gaps.
- Sits between the client logic and the SDRAM controller in the core top level.

Parameters:
- NCLIENT, 3, number of requesters (2..8).
- RFSH_PERIOD, 400, idle-refresh interval in clk cycles.
- RFSH_HOLD, 8, cycles grants are blocked after a refresh pulse.
- TIMEOUT, 63, max cycles waiting for ch3_ready before aborting.

Ports:
- clk  in  1  controller clock, same clock as the SDRAM controller.
- reset_n  in  1  asynchronous active-low reset.
- cl_req  in  NCLIENT  per-client request, level; held until the matching cl_ack.
- cl_rnw  in  NCLIENT  per-client direction: 1 = read, 0 = write.
- cl_addr  in  NCLIENT*26  per-client word address [26:1]; slice i = bits [26*i+25 : 26*i].
- cl_din  in  NCLIENT*16  per-client write data.
- cl_be  in  NCLIENT*2  per-client byte enables, [1] = upper byte.
- cl_ack  out  NCLIENT  one-cycle completion pulse to the granted client.
- cl_dout  out  16  read data; valid in the cycle cl_ack is high.
- cl_err  out  1  high with cl_ack when the access timed out.
- ch3_req  out  1  request to the controller; the rising edge starts an access.
- ch3_rnw  out  1  direction to the controller.
- ch3_addr  out  26  address [26:1] to the controller.
- ch3_din  out  16  write data to the controller.
- ch3_be  out  2  byte enables to the controller.
- ch3_ready  in  1  one-cycle completion from the controller.
- ch3_dout  in  16  read data from the controller, valid with ch3_ready.
- doRefresh  out  1  one-cycle refresh request to the controller.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE, all outputs 0, round-robin pointer 0, refresh counter 0, timeout counter 0.
  - Reset mid-access: ch3_req drops immediately and no cl_ack is issued. The client must re-request after reset.
- Refresh counter: increments every cycle, saturating at RFSH_PERIOD, and clears when doRefresh pulses.
- IDLE:
  - If the refresh counter has reached RFSH_PERIOD: pulse doRefresh for 1 cycle and go to RFSH. Refresh takes priority over pending client requests.
  - Else if any cl_req is high: grant the first requesting client at or after the pointer (pointer = last grant + 1, mod NCLIENT).
    - Register that client's rnw/addr/din/be onto the ch3_* outputs.
    - Set ch3_req = 1, clear the timeout counter, go to ISSUE.
- ISSUE:
  - ch3_req and all ch3_* fields stay constant.
  - On ch3_ready: capture ch3_dout into cl_dout (reads only; cl_dout is unchanged for writes), go to ACK.
  - If the timeout counter reaches TIMEOUT first: go to ACK with the error flag set.
  - If ch3_ready and timeout occur in the same cycle, ready wins and cl_err = 0.
  - A ch3_ready arriving outside ISSUE is ignored.
- ACK:
  - ch3_req = 0.
  - cl_ack[grant] = 1 for exactly 1 cycle, cl_err = error flag.
  - Pointer advances to grant + 1, wrapping from NCLIENT-1 to 0. Go to GAP.
- GAP:
  - 1 cycle; no request sampling.
  - Guarantees ch3_req is low for at least 2 cycles, so the controller sees a clean rising edge on the next access.
  - Gives the client one cycle to drop cl_req after cl_ack.
  - Go to IDLE.
- RFSH: block grants for RFSH_HOLD cycles, then go to IDLE.
- Latency: cl_req sampled in IDLE -> ch3_req high next cycle. ch3_ready -> cl_ack 1 cycle later.
- Back-to-back: a client holding cl_req high after GAP is treated as a new request with its current fields.
- cl_ack is never high for more than one client at a time. cl_ack and cl_err are 0 outside ACK.
- A client whose cl_req falls before it is granted is simply not granted. There is no abort once in ISSUE.

Test Plan:
- Single write: client 0 writes addr 0x0001234, din 0xBEEF, be 2'b11; ready after 4 cycles -> ch3_req rises once with those fields held; cl_ack[0] one cycle after ready; cl_err = 0.
- Single read: client 1 reads; ch3_dout = 0x5A5A with ready -> cl_dout = 0x5A5A and cl_ack[1] in the same cycle; cl_dout holds its value afterwards.
- Fairness: all 3 clients request continuously with pointer 0 -> grants in order 0,1,2,0,1,2; ch3_req low at least 2 cycles between accesses.
- Refresh: with RFSH_PERIOD = 20 and requests pending when the counter hits 20 -> doRefresh pulses 1 cycle; no grant for 8 cycles; then the next grant proceeds.
- Timeout: ch3_ready never asserted -> after 63 ISSUE cycles, cl_ack pulses with cl_err = 1; ch3_req drops; the next client is granted.
- Reset mid-ISSUE: reset_n low during an access -> ch3_req = 0 immediately and no ack; after release, the first request is granted from pointer 0.
